// File: rtl/fir_tap_sequencer_if.sv
// Handshake and tap-stream bundle between the sample/coefficient producer,
// the tap sequencer and the downstream MAC stage.
interface fir_tap_sequencer_if #(
  parameter int DATA_W = 21,
  parameter int COEF_W = 21,
  parameter int AW     = 3
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic [DATA_W-1:0] tap_sample;
  logic [COEF_W-1:0] tap_coef;
  logic              tap_valid;
  logic              tap_first;
  logic              tap_last;

  modport master (
    output sample_in, sample_valid, coef_we, coef_addr, coef_data,
    input  sample_ready, tap_sample, tap_coef, tap_valid, tap_first, tap_last
  );

  modport slave (
    input  sample_in, sample_valid, coef_we, coef_addr, coef_data,
    output sample_ready, tap_sample, tap_coef, tap_valid, tap_first, tap_last
  );
endinterface

// File: rtl/fir_tap_sequencer.sv
// Streams (x[n-k], h[k]) pairs, k = 0..TAPS-1, one per clock for every
// accepted sample, out of a circular sample history and a coefficient file.
module fir_tap_sequencer #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 21,
  parameter int COEF_W = 21,
  parameter int AW     = 3
) (
  input  logic                clk,
  input  logic                reset,
  fir_tap_sequencer_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                    state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [AW-1:0]             wr_ptr_q;
  logic [AW-1:0]             newest_q;
  logic signed [DATA_W-1:0]  hist_q [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];

  logic signed [DATA_W-1:0]  tap_sample_q, tap_sample_d;
  logic signed [COEF_W-1:0]  tap_coef_q, tap_coef_d;
  logic                      vld_q, vld_d;
  logic                      first_q, first_d;
  logic                      last_q, last_d;

  logic                      accept;
  logic                      load;
  logic [AW-1:0]             ld_idx;
  logic [AW-1:0]             rd_ptr;

  // The output registers are loaded one cycle ahead of presentation: tap 0 on
  // the handshake edge (bypassing the history write), tap k+1 while k is shown.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    accept       = 1'b0;
    load         = 1'b0;
    ld_idx       = '0;
    rd_ptr       = '0;
    tap_sample_d = '0;
    tap_coef_d   = '0;
    vld_d        = 1'b0;
    first_d      = 1'b0;
    last_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.sample_valid) begin
          accept  = 1'b1;
          load    = 1'b1;
          ld_idx  = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (idx_q == AW'(TAPS - 1)) begin
          state_d = IDLE;
        end else begin
          load   = 1'b1;
          ld_idx = idx_q + AW'(1);
          idx_d  = ld_idx;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      rd_ptr       = newest_q - ld_idx;
      tap_sample_d = accept ? bus.sample_in : hist_q[rd_ptr];
      tap_coef_d   = coef_q[ld_idx];
      vld_d        = 1'b1;
      first_d      = (ld_idx == '0);
      last_d       = (ld_idx == AW'(TAPS - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_ptr_q     <= '0;
      newest_q     <= '0;
      tap_sample_q <= '0;
      tap_coef_q   <= '0;
      vld_q        <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tap_sample_q <= tap_sample_d;
      tap_coef_q   <= tap_coef_d;
      vld_q        <= vld_d;
      first_q      <= first_d;
      last_q       <= last_d;
      if (accept) begin
        hist_q[wr_ptr_q] <= bus.sample_in;
        newest_q         <= wr_ptr_q;
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      // Same-edge reads above see the old coefficient; later taps see the new one.
      if (bus.coef_we) begin
        coef_q[bus.coef_addr] <= bus.coef_data;
      end
    end
  end

  assign bus.sample_ready = (state_q == IDLE);
  assign bus.tap_sample   = tap_sample_q;
  assign bus.tap_coef     = tap_coef_q;
  assign bus.tap_valid    = vld_q;
  assign bus.tap_first    = first_q;
  assign bus.tap_last     = last_q;

endmodule
